shift_add_tree_pipe: RTL and testbench

Pipelined, parametrised shift-and-add reduction tree for the variable-precision temporal MAC. It takes NUM_IN signed partial-product slices and recombines them level by level into wider results. Each level computes (hi << shift) + lo over adjacent lane pairs, with the shift doubling at every level. A per-transaction mode selects how many levels actually combine, so one instance serves 2/4/8/…-slice operand precisions. It sits between the slice multiplier array and the accumulator, with valid/ready handshakes on both sides.

---
 rtl/shift_add_pkg.sv | 19 +
 rtl/shift_add_level.sv | 64 ++++++
 rtl/shift_add_tree_pipe.sv | 94 +++++++++
 tb/tb_shift_add_tree_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_pkg.sv
// Shared types and helpers for the shift-and-add reduction tree.
// Default sizing matches the 8-lane, 3-level configuration.
package shift_add_pkg;

    localparam int unsigned DEF_NUM_IN    = 8;
    localparam int unsigned DEF_LEVELS    = $clog2(DEF_NUM_IN);
    localparam int unsigned DEF_MODE_BITS = $clog2(DEF_LEVELS + 1);

    typedef logic [DEF_MODE_BITS-1:0] mode_t;

    function automatic int unsigned lanes_active(input int unsigned num_in, input int unsigned mode);
        return num_in >> mode;
    endfunction

    function automatic int unsigned level_shift(input int unsigned slice_bits, input int unsigned k);
        return slice_bits << k;
    endfunction

endpackage

// File: rtl/shift_add_level.sv
// One register stage of the reduction tree: pairwise (hi << SHIFT) + lo
// when this level is enabled by the beat's mode, otherwise a straight copy.
module shift_add_level
    import shift_add_pkg::*;
#(
    parameter int unsigned LANES     = 8,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned SHIFT     = 2,
    parameter int unsigned LEVEL_IDX = 0,
    parameter int unsigned MODE_W    = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             up_valid,
    input  logic [LANES-1:0][OUT_WIDTH-1:0]  up_data,
    input  logic [MODE_W-1:0]                up_mode,
    input  logic                             dn_ready,
    output logic                             valid_q,
    output logic [LANES-1:0][OUT_WIDTH-1:0]  data_q,
    output logic [MODE_W-1:0]                mode_q
);

    localparam int unsigned PAIRS = lanes_active(LANES, LEVEL_IDX) / 2;

    logic                             local_ready;
    logic                             load;
    logic                             valid_d;
    logic [LANES-1:0][OUT_WIDTH-1:0]  comb_data;
    logic [LANES-1:0][OUT_WIDTH-1:0]  data_d;
    logic [MODE_W-1:0]                mode_d;

    assign local_ready = !valid_q || dn_ready;
    assign load        = up_valid && local_ready;

    always_comb begin
        comb_data = '0;
        if (32'(up_mode) > LEVEL_IDX) begin
            for (int unsigned j = 0; j < PAIRS; j++) begin
                comb_data[j] = (up_data[2*j+1] << SHIFT) + up_data[2*j];
            end
        end else begin
            comb_data = up_data;
        end
    end

    always_comb begin
        valid_d = local_ready ? up_valid : valid_q;
        data_d  = load ? comb_data : data_q;
        mode_d  = load ? up_mode : mode_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mode_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: rtl/shift_add_tree_pipe.sv
// Pipelined shift-and-add reduction tree with per-beat level count (mode)
// and valid/ready handshakes on both sides; one register stage per level.
module shift_add_tree_pipe
    import shift_add_pkg::*;
#(
    parameter int unsigned NUM_IN     = 8,
    parameter int unsigned IN_WIDTH   = 10,
    parameter int unsigned SLICE_BITS = 2,
    parameter int unsigned OUT_WIDTH  = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NUM_IN-1:0][IN_WIDTH-1:0]      in_data,
    input  logic [$clog2($clog2(NUM_IN)+1)-1:0]  in_mode,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NUM_IN-1:0][OUT_WIDTH-1:0]     out_data,
    output logic [$clog2($clog2(NUM_IN)+1)-1:0]  out_mode
);

    localparam int unsigned LEVELS = $clog2(NUM_IN);
    localparam int unsigned MODE_W = $clog2(LEVELS + 1);

    logic [NUM_IN-1:0][OUT_WIDTH-1:0]  ent_data;
    logic [MODE_W-1:0]                 ent_mode;
    logic [NUM_IN-1:0][OUT_WIDTH-1:0]  q_data [LEVELS];
    logic [MODE_W-1:0]                 q_mode [LEVELS];
    logic [LEVELS-1:0]                 q_valid;
    logic [LEVELS:0]                   rdy;

    always_comb begin
        ent_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            ent_data[i] = OUT_WIDTH'($signed(in_data[i]));
        end
        ent_mode = (32'(in_mode) > LEVELS) ? MODE_W'(LEVELS) : in_mode;
    end

    // Ready chain evaluated back-to-front from the stage valid bits so that
    // a full pipe unblocks in the same cycle out_ready rises.
    always_comb begin
        logic chain;
        rdy   = '0;
        chain = out_ready;
        rdy[LEVELS] = chain;
        for (int k = int'(LEVELS) - 1; k >= 0; k--) begin
            chain  = !q_valid[k] || chain;
            rdy[k] = chain;
        end
    end

    assign in_ready = rdy[0];

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        logic                             up_valid;
        logic [NUM_IN-1:0][OUT_WIDTH-1:0] up_data;
        logic [MODE_W-1:0]                up_mode;

        if (k == 0) begin : g_first
            assign up_valid = in_valid;
            assign up_data  = ent_data;
            assign up_mode  = ent_mode;
        end else begin : g_next
            assign up_valid = q_valid[k-1];
            assign up_data  = q_data[k-1];
            assign up_mode  = q_mode[k-1];
        end

        shift_add_level #(
            .LANES     (NUM_IN),
            .OUT_WIDTH (OUT_WIDTH),
            .SHIFT     (level_shift(SLICE_BITS, k)),
            .LEVEL_IDX (k),
            .MODE_W    (MODE_W)
        ) u_level (
            .clk      (clk),
            .rst      (rst),
            .up_valid (up_valid),
            .up_data  (up_data),
            .up_mode  (up_mode),
            .dn_ready (rdy[k+1]),
            .valid_q  (q_valid[k]),
            .data_q   (q_data[k]),
            .mode_q   (q_mode[k])
        );
    end

    assign out_valid = q_valid[LEVELS-1];
    assign out_data  = q_data[LEVELS-1];
    assign out_mode  = q_mode[LEVELS-1];

endmodule

// File: tb/tb_shift_add_tree_pipe.sv
// Self-checking bench for shift_add_tree_pipe: directed scenarios plus a
// randomized stream scored against a closed-form weighted-sum model.
`timescale 1ns/1ps
module tb_shift_add_tree_pipe;

    typedef logic [7:0][31:0] lanes_t;
    typedef logic [7:0][9:0]  slices_t;
    typedef struct { lanes_t data; logic [1:0] mode; } beat_t;

    localparam int unsigned SB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic in_valid, in_ready, out_valid, out_ready;
    slices_t in_data;
    lanes_t out_data;
    logic [1:0] in_mode, out_mode;

    logic w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    slices_t w_in_data;
    logic [7:0][15:0] w_out_data;
    logic [1:0] w_in_mode, w_out_mode;

    logic c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [3:0][9:0] c_in_data;
    logic [3:0][31:0] c_out_data;
    logic [1:0] c_in_mode, c_out_mode;

    int checks = 0;
    int errors = 0;
    beat_t exp_q[$];
    beat_t got_q[$];

    shift_add_tree_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
    );

    shift_add_tree_pipe #(.OUT_WIDTH(16)) dut_w (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_data(w_in_data), .in_mode(w_in_mode), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .out_data(w_out_data), .out_mode(w_out_mode)
    );

    shift_add_tree_pipe #(.NUM_IN(4)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_mode(c_in_mode), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .out_mode(c_out_mode)
    );

    // Output lane j of a beat is the weighted sum of its group of 2^mode input
    // slices, slice i of the group weighted by 2^(SB*i), taken modulo 2^w.
    function automatic lanes_t model(input slices_t din, input int unsigned n,
                                     input int unsigned mode, input int unsigned w);
        int unsigned levels = $clog2(n);
        int unsigned m = (mode > levels) ? levels : mode;
        int unsigned g = 1 << m;
        logic [63:0] mask = (64'd1 << w) - 64'd1;
        lanes_t r = '0;
        for (int unsigned j = 0; j < n / g; j++) begin
            longint acc = 0;
            for (int unsigned i = 0; i < g; i++)
                acc += longint'($signed(din[j*g+i])) <<< (SB * i);
            r[j] = 32'(acc & mask);
        end
        return r;
    endfunction

    function automatic slices_t rand_slices();
        slices_t d;
        for (int i = 0; i < 8; i++) d[i] = 10'($urandom);
        return d;
    endfunction

    // Advance one cycle, recording accepted beats (via the model) and popped results.
    task automatic cycle(output logic acc, output logic pop);
        @(negedge clk);
        acc = !rst && in_valid && in_ready;
        pop = !rst && out_valid && out_ready;
        if (rst) exp_q.delete();
        if (acc) exp_q.push_back('{model(in_data, 8, in_mode, 32), in_mode});
        if (pop) got_q.push_back('{out_data, out_mode});
        @(posedge clk); #1;
    endtask

    task automatic send_one(input slices_t d, input logic [1:0] m,
                            output lanes_t od, output logic [1:0] om, output int lat);
        in_data = d; in_mode = m; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1; od = '0; om = '0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) begin lat = c; od = out_data; om = out_mode; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = rand_slices(); in_mode = 2'd3; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_data got %h want 0", out_data); end
        checks++; if (out_mode !== 2'd0) begin errors++; $display("FAIL rst_mode got %0d want 0", out_mode); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        rst = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin logic a, p; cycle(a, p); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rst_no_accept got %0d beats want 0", got_q.size()); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_full_combine();
        slices_t d; lanes_t od, e; logic [1:0] om; int lat;
        for (int i = 0; i < 8; i++) d[i] = 10'd1;
        e = model(d, 8, 3, 32);
        send_one(d, 2'd3, od, om, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL full_latency got %0d want 2", lat); end
        checks++; if (od !== e) begin errors++; $display("FAIL full_data got %h want %h", od, e); end
        checks++; if (od[0] !== 32'h5555 || od[7:1] !== '0) begin errors++; $display("FAIL full_lane0 got %h want 00005555 and upper 0", od); end
        checks++; if (om !== 2'd3) begin errors++; $display("FAIL full_mode got %0d want 3", om); end
    endtask

    task automatic test_partial_pass();
        slices_t d; lanes_t od, e; logic [1:0] om; int lat;
        d = '0; d[0] = 10'd1; d[1] = 10'd2; d[2] = 10'd7; d[3] = 10'd0;
        e = model(d, 8, 1, 32);
        send_one(d, 2'd1, od, om, lat);
        checks++; if (od !== e) begin errors++; $display("FAIL partial_data got %h want %h", od, e); end
        checks++; if (od[0] !== 32'd9 || od[1] !== 32'd7 || od[7:2] !== '0) begin errors++; $display("FAIL partial_lanes got %h want lane0=9 lane1=7", od); end
        checks++; if (om !== 2'd1) begin errors++; $display("FAIL partial_mode got %0d want 1", om); end
        d = rand_slices();
        e = model(d, 8, 0, 32);
        send_one(d, 2'd0, od, om, lat);
        checks++; if (od !== e || lat != 2) begin errors++; $display("FAIL pass_data got %h lat %0d want %h lat 2", od, lat, e); end
        checks++; if (om !== 2'd0) begin errors++; $display("FAIL pass_mode got %0d want 0", om); end
    endtask

    task automatic test_sign_clamp();
        slices_t d; lanes_t od, e; logic [1:0] om; int lat;
        d = '0; d[1] = 10'h3FF; d[0] = 10'd3;
        send_one(d, 2'd1, od, om, lat);
        checks++; if (od[0] !== 32'hFFFF_FFFF || od !== model(d, 8, 1, 32)) begin errors++; $display("FAIL sign_lane0 got %h want ffffffff", od[0]); end
        d = '0;
        for (int i = 0; i < 4; i++) d[i] = 10'($urandom);
        e = model(d, 4, 3, 32);
        c_in_data = d[3:0]; c_in_mode = 2'd3; c_in_valid = 1'b1;
        @(posedge clk); #1;
        c_in_valid = 1'b0; lat = -1;
        for (int c = 0; c < 10; c++) begin
            if (c_out_valid) begin lat = c; break; end
            @(posedge clk); #1;
        end
        checks++; if (lat < 0) begin errors++; $display("FAIL clamp_timeout got no out_valid want out_valid"); end
        checks++; if (c_out_mode !== 2'd2) begin errors++; $display("FAIL clamp_mode got %0d want 2", c_out_mode); end
        checks++; if (c_out_data !== e[3:0]) begin errors++; $display("FAIL clamp_data got %h want %h", c_out_data, e[3:0]); end
    endtask

    task automatic test_wrap();
        slices_t d; lanes_t e; logic [7:0][15:0] ew; int lat;
        for (int i = 0; i < 8; i++) d[i] = 10'h1FF;
        e = model(d, 8, 3, 16);
        for (int j = 0; j < 8; j++) ew[j] = e[j][15:0];
        w_in_data = d; w_in_mode = 2'd3; w_in_valid = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0; lat = -1;
        for (int c = 0; c < 10; c++) begin
            if (w_out_valid) begin lat = c; break; end
            @(posedge clk); #1;
        end
        checks++; if (lat != 2) begin errors++; $display("FAIL wrap_latency got %0d want 2", lat); end
        checks++; if (w_out_data !== ew) begin errors++; $display("FAIL wrap_data got %h want %h", w_out_data, ew); end
        checks++; if (w_out_data[0] !== 16'h54AB) begin errors++; $display("FAIL wrap_lane0 got %h want 54ab", w_out_data[0]); end
    endtask

    task automatic test_back_pressure();
        slices_t bd [5]; logic [1:0] bm [5];
        int b = 0; int c = 0; int first_pop = -1; int last_pop = -1;
        logic acc, pop; lanes_t held; logic [1:0] held_m;
        for (int i = 0; i < 5; i++) begin bd[i] = rand_slices(); bm[i] = 2'($urandom_range(0, 3)); end
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = bd[b]; in_mode = bm[b];
            cycle(acc, pop);
            if (acc) b++;
        end
        checks++; if (b != 3) begin errors++; $display("FAIL bp_accepted got %0d want 3", b); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        held = out_data; held_m = out_mode;
        repeat (3) cycle(acc, pop);
        checks++; if (out_valid !== 1'b1 || out_data !== held || out_mode !== held_m) begin errors++; $display("FAIL bp_stable got %h want %h", out_data, held); end
        out_ready = 1'b1;
        while (got_q.size() < 5 && c < 20) begin
            in_valid = (b < 5); in_data = bd[b < 5 ? b : 4]; in_mode = bm[b < 5 ? b : 4];
            cycle(acc, pop);
            if (acc) b++;
            if (pop) begin if (first_pop < 0) first_pop = c; last_pop = c; end
            c++;
        end
        in_valid = 1'b0;
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL bp_count got %0d want 5", got_q.size()); end
        checks++; if (last_pop - first_pop != 4) begin errors++; $display("FAIL bp_rate got span %0d want 4", last_pop - first_pop); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            beat_t g = got_q.pop_front(); beat_t e = exp_q.pop_front();
            checks++; if (g.data !== e.data || g.mode !== e.mode) begin errors++; $display("FAIL bp_order got %h/%0d want %h/%0d", g.data, g.mode, e.data, e.mode); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random_stream();
        logic acc, pop; int c = 0;
        for (int k = 0; k < 200; k++) begin
            if (!in_valid || acc) begin
                in_data = rand_slices(); in_mode = 2'($urandom_range(0, 3));
            end
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            cycle(acc, pop);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        while (got_q.size() < exp_q.size() && c < 20) begin cycle(acc, pop); c++; end
        checks++; if (got_q.size() != exp_q.size() || got_q.size() == 0) begin errors++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            beat_t g = got_q.pop_front(); beat_t e = exp_q.pop_front();
            checks++; if (g.data !== e.data || g.mode !== e.mode) begin errors++; $display("FAIL rand_beat got %h/%0d want %h/%0d", g.data, g.mode, e.data, e.mode); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midstream();
        logic acc, pop; int n_acc = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_data = rand_slices(); in_mode = 2'd3;
            cycle(acc, pop);
            if (acc) n_acc++;
        end
        checks++; if (n_acc != 2) begin errors++; $display("FAIL mid_accept got %0d want 2", n_acc); end
        rst = 1'b1; in_data = rand_slices();
        cycle(acc, pop);
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset got v=%b d=%h r=%b want 0/0/1", out_valid, out_data, in_ready); end
        rst = 1'b0; in_valid = 1'b0;
        repeat (6) cycle(acc, pop);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mid_discard got %0d beats want 0", got_q.size()); end
    endtask

    initial begin
        logic a0, p0;
        a0 = 1'b0; p0 = 1'b0;
        w_in_valid = 1'b0; w_in_data = '0; w_in_mode = '0; w_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_data = '0; c_in_mode = '0; c_out_ready = 1'b1;
        test_reset();
        test_full_combine();
        test_partial_pass();
        test_sign_clamp();
        test_wrap();
        test_back_pressure();
        test_random_stream();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
